// File: rtl/commit_unit_pkg.sv
// rtl/commit_unit_pkg.sv - shared CSR map, trap constants and FSM encoding for commit_unit
package commit_unit_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // Environment call from M-mode
  localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;
  // MPP = 2'b11 (machine mode) out of reset
  localparam logic [31:0] MSTATUS_RESET  = 32'h0000_1800;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_t;

endpackage

// File: rtl/gpr_file.sv
// rtl/gpr_file.sv - general-purpose register array, one write port, two read ports, x0 hardwired
module gpr_file #(
  parameter int NR_GPR = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wen,
  input  logic [$clog2(NR_GPR)-1:0]   waddr,
  input  logic [31:0]                 wdata,
  input  logic [$clog2(NR_GPR)-1:0]   raddr1,
  input  logic [$clog2(NR_GPR)-1:0]   raddr2,
  output logic [31:0]                 rdata1,
  output logic [31:0]                 rdata2
);

  logic [31:0] regs [NR_GPR];

  // Clear on reset; writes to x0 are dropped so it never holds a value
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR_GPR; i++) begin
        regs[i] <= '0;
      end
    end else if (wen && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Reads see pre-edge contents; there is deliberately no write bypass
  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/commit_unit.sv
// rtl/commit_unit.sv - architectural commit of GPR/CSR writes and next-PC handoff to fetch
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int NR_GPR = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_valid,
  output logic                       wb_ready,
  input  logic [31:0]                wb_pc,
  input  logic [31:0]                wb_dnpc,
  input  logic                       gpr_wen,
  input  logic [$clog2(NR_GPR)-1:0]  rd,
  input  logic [31:0]                gpr_wdata,
  input  logic                       csr_wen,
  input  logic [11:0]                csr_waddr,
  input  logic [31:0]                csr_wdata,
  input  logic                       is_ecall,
  input  logic                       is_mret,
  input  logic [$clog2(NR_GPR)-1:0]  rs1,
  input  logic [$clog2(NR_GPR)-1:0]  rs2,
  output logic [31:0]                rdata1,
  output logic [31:0]                rdata2,
  input  logic [11:0]                csr_raddr,
  output logic [31:0]                csr_rdata,
  output logic [31:0]                mtvec_out,
  output logic [31:0]                mepc_out,
  output logic                       npc_valid,
  input  logic                       npc_ready,
  output logic [31:0]                npc
);

  state_t      state, state_next;
  logic        commit;
  logic [31:0] mstatus, mtvec, mepc, mcause;
  logic        mret_unused;

  assign wb_ready  = (state == ST_IDLE);
  assign npc_valid = (state == ST_REDIRECT);
  assign commit    = wb_valid && wb_ready;

  // mret changes no CSR here; writeback already built its dnpc from mepc_out
  assign mret_unused = is_mret;

  // Next-state: one commit, then hold the redirect until fetch takes it
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (commit)    state_next = ST_REDIRECT;
      ST_REDIRECT: if (npc_ready) state_next = ST_IDLE;
      default:                    state_next = ST_IDLE;
    endcase
  end

  // State register; reset drops any pending redirect
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Latch the committed instruction's next PC; held stable through REDIRECT
  always_ff @(posedge clk) begin
    if (rst)         npc <= '0;
    else if (commit) npc <= wb_dnpc;
  end

  // CSR writes; the ecall assignments come last so the trap overrides mepc/mcause writes
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus <= MSTATUS_RESET;
      mtvec   <= '0;
      mepc    <= '0;
      mcause  <= '0;
    end else if (commit) begin
      if (csr_wen) begin
        case (csr_waddr)
          CSR_MSTATUS: mstatus <= csr_wdata;
          CSR_MTVEC:   mtvec   <= csr_wdata;
          CSR_MEPC:    mepc    <= csr_wdata;
          CSR_MCAUSE:  mcause  <= csr_wdata;
          default:     ;
        endcase
      end
      if (is_ecall) begin
        mepc   <= wb_pc;
        mcause <= MCAUSE_ECALL_M;
      end
    end
  end

  // Combinational CSR read; unimplemented addresses read as zero
  always_comb begin
    csr_rdata = '0;
    case (csr_raddr)
      CSR_MSTATUS: csr_rdata = mstatus;
      CSR_MTVEC:   csr_rdata = mtvec;
      CSR_MEPC:    csr_rdata = mepc;
      CSR_MCAUSE:  csr_rdata = mcause;
      default:     csr_rdata = '0;
    endcase
  end

  assign mtvec_out = mtvec;
  assign mepc_out  = mepc;

  gpr_file #(.NR_GPR(NR_GPR)) u_gpr_file (
    .clk    (clk),
    .rst    (rst),
    .wen    (commit && gpr_wen),
    .waddr  (rd),
    .wdata  (gpr_wdata),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

endmodule

// File: doc/commit_unit.md
COMMIT_UNIT -- requirements
Module: commit_unit

Interface
REQ-001 SHALL have parameter NR_GPR, 32, number of general-purpose registers; index width is log2(NR_GPR).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports wb_valid in 1, wb_ready out 1  commit handshake from the writeback stage.
REQ-005 SHALL have ports wb_pc in 32, wb_dnpc in 32  committed instruction PC and its next PC.
REQ-006 SHALL have ports gpr_wen in 1, rd in 5, gpr_wdata in 32  register writeback.
REQ-007 SHALL have ports csr_wen in 1, csr_waddr in 12, csr_wdata in 32, is_ecall in 1, is_mret in 1  CSR and trap commit.
REQ-008 SHALL have ports rs1 in 5, rs2 in 5, rdata1 out 32, rdata2 out 32  combinational GPR reads.
REQ-009 SHALL have ports csr_raddr in 12, csr_rdata out 32, mtvec_out out 32, mepc_out out 32  combinational CSR reads.
REQ-010 SHALL have ports npc_valid out 1, npc_ready in 1, npc out 32  next-PC handoff to fetch.

Function
REQ-011 SHALL implement FSM IDLE/REDIRECT; wb_ready = (state==IDLE).
REQ-012 IDLE: on wb_valid&&wb_ready, SHALL commit all writes at that edge, latch npc=wb_dnpc, go REDIRECT.
REQ-013 REDIRECT: npc_valid=1, npc stable; on npc_ready SHALL return to IDLE at that edge; no new commit accepted while in REDIRECT.
REQ-014 Commit-to-npc_valid latency SHALL be exactly 1 cycle; back-to-back commits SHALL be spaced at least 2 cycles.
REQ-015 GPR write SHALL occur only when gpr_wen=1 and rd!=0; x0 SHALL always read 0.
REQ-016 CSRs SHALL be mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342; csr_wen to these SHALL write csr_wdata; other addresses ignored on write, read as 0.
REQ-017 is_ecall SHALL set mepc=wb_pc and mcause=32'd11 (M-mode ecall).
REQ-018 is_ecall with csr_wen to mepc/mcause in the same commit: trap update SHALL win; writes to other CSRs still apply.
REQ-019 is_mret SHALL cause no CSR change; mepc_out SHALL expose mepc for the writeback stage's dnpc.
REQ-020 Reads SHALL return pre-edge contents (no write-to-read bypass).
REQ-021 Inputs other than wb_valid SHALL be ignored when no handshake occurs.

Reset
REQ-022 On rst: state=IDLE, npc_valid=0, npc=0, all GPRs=0, mstatus=32'h1800, mtvec=mepc=mcause=0.
REQ-023 rst SHALL take priority over any same-cycle commit or npc handshake; reset in REDIRECT SHALL drop the pending npc.

Structure
REQ-024 CSR addresses, mcause code 11, mstatus reset value and FSM state encoding SHALL live in a shared package.
REQ-025 The GPR array SHALL be a sub-module gpr_file (1 write, 2 read ports, x0 hardwired); CSRs and FSM stay in commit_unit.

Verification
REQ-026 Reset then read: rs1=5, csr_raddr=0x300 -> rdata1=0, csr_rdata=32'h1800, wb_ready=1, npc_valid=0.
REQ-027 Commit gpr_wen=1, rd=5, gpr_wdata=32'hDEADBEEF, wb_dnpc=32'h80000004 -> next cycle rdata1(rs1=5)=32'hDEADBEEF, npc_valid=1, npc=32'h80000004, wb_ready=0.
REQ-028 Commit rd=0, gpr_wdata=32'h1234 -> rdata(rs1=0)=0.
REQ-029 ecall at wb_pc=32'h80000100 with csr_wen to 0x341 data 32'h5 -> mepc_out=32'h80000100, mcause=11.
REQ-030 Hold npc_ready=0 for 3 cycles in REDIRECT with wb_valid=1 -> npc stable, wb_ready=0, no GPR change; npc_ready=1 -> IDLE next cycle.
REQ-031 Assert rst in REDIRECT -> next cycle npc_valid=0, state IDLE, GPRs 0.
